// File: rtl/mvu_job_ctrl.sv
`default_nettype none
// mvu_job_ctrl: sequences one MVU job as bit-serial read beats, a drain wait and a granted write-back.
// Rev 1.0 - initial release.
module mvu_job_ctrl #(
  parameter int BWBANKA  = 9,
  parameter int BDBANKA  = 14,
  parameter int PIPE_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         cfg_mode,
  input  logic [3:0]         cfg_iprec,
  input  logic [8:0]         cfg_len,
  input  logic [8:0]         cfg_nout,
  input  logic [BWBANKA-1:0] cfg_wbase,
  input  logic [BDBANKA-1:0] cfg_ibase,
  input  logic [BDBANKA-1:0] cfg_obase,
  input  logic               cfg_max_en,
  input  logic               cfg_max_pool,
  output logic               busy,
  output logic               done,
  output logic [1:0]         mul_mode,
  output logic               acc_clr,
  output logic               acc_sh,
  output logic               max_en,
  output logic               max_clr,
  output logic               max_pool,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr
);

  localparam int            DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         mode_q,  mode_d;
  logic [3:0]         iprec_q, iprec_d;
  logic [8:0]         len_q,   len_d;
  logic [8:0]         nout_q,  nout_d;
  logic [BWBANKA-1:0] wbase_q, wbase_d;
  logic [BDBANKA-1:0] ibase_q, ibase_d;
  logic [BDBANKA-1:0] obase_q, obase_d;
  logic               mxen_q,  mxen_d;
  logic               mxpl_q,  mxpl_d;

  logic [8:0]         o_q, o_d;
  logic [3:0]         b_q, b_d;
  logic [8:0]         t_q, t_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;

  logic               busy_q, busy_d, done_q, done_d;
  logic [1:0]         mul_mode_q, mul_mode_d;
  logic               acc_clr_q, acc_clr_d, acc_sh_q, acc_sh_d;
  logic               max_en_q, max_en_d, max_clr_q, max_clr_d, max_pool_q, max_pool_d;
  logic [BWBANKA-1:0] rdw_addr_q, rdw_addr_d;
  logic               rdd_en_q, rdd_en_d;
  logic [BDBANKA-1:0] rdd_addr_q, rdd_addr_d;
  logic               wrd_en_q, wrd_en_d;
  logic [BDBANKA-1:0] wrd_addr_q, wrd_addr_d;

  logic [3:0]         plane;
  logic               run_d;
  logic               first_d;

  // Sequencing: state and counters
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    iprec_d = iprec_q;
    len_d   = len_q;
    nout_d  = nout_q;
    wbase_d = wbase_q;
    ibase_d = ibase_q;
    obase_d = obase_q;
    mxen_d  = mxen_q;
    mxpl_d  = mxpl_q;
    o_d     = o_q;
    b_d     = b_q;
    t_d     = t_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = cfg_mode;
          iprec_d = cfg_iprec;
          len_d   = cfg_len;
          nout_d  = cfg_nout;
          wbase_d = cfg_wbase;
          ibase_d = cfg_ibase;
          obase_d = cfg_obase;
          mxen_d  = cfg_max_en;
          mxpl_d  = cfg_max_pool;
          o_d     = 9'd0;
          b_d     = cfg_iprec - 4'd1;
          t_d     = 9'd0;
          if (cfg_iprec == 4'd0 || cfg_len == 9'd0 || cfg_nout == 9'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (rdd_grnt) begin
          if (t_q == len_q - 9'd1) begin
            t_d = 9'd0;
            if (b_q == 4'd0) begin
              state_d = S_DRAIN;
              dcnt_d  = DRAIN_LAST;
            end else begin
              b_d = b_q - 4'd1;
            end
          end else begin
            t_d = t_q + 9'd1;
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == '0) begin
          state_d = S_WRITE;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      S_WRITE: begin
        if (wrd_grnt) begin
          if (o_q == nout_q - 9'd1) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
            o_d     = o_q + 9'd1;
            b_d     = iprec_q - 4'd1;
            t_d     = 9'd0;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state; the MSB plane sits at ibase, so the
  // plane offset grows as b counts down.
  always_comb begin
    run_d      = (state_d == S_RUN);
    plane      = iprec_d - 4'd1 - b_d;
    first_d    = (b_d == iprec_d - 4'd1) && (t_d == 9'd0);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_FIN);
    mul_mode_d = busy_d ? mode_d : 2'd0;
    max_en_d   = busy_d & mxen_d;
    max_pool_d = busy_d & mxpl_d;
    rdd_en_d   = run_d;
    acc_clr_d  = run_d & first_d;
    acc_sh_d   = run_d & (t_d == 9'd0) & ~first_d;
    max_clr_d  = run_d & first_d & (o_d == 9'd0);
    rdd_addr_d = '0;
    rdw_addr_d = '0;
    if (run_d) begin
      rdd_addr_d = BDBANKA'(32'(ibase_d) + 32'(plane) * 32'(len_d) + 32'(t_d));
      rdw_addr_d = BWBANKA'(32'(wbase_d) + 32'(o_d) * 32'(len_d) + 32'(t_d));
    end
    wrd_en_d   = (state_d == S_WRITE);
    wrd_addr_d = '0;
    if (state_d == S_WRITE) begin
      wrd_addr_d = BDBANKA'(32'(obase_d) + 32'(o_d));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      iprec_q    <= '0;
      len_q      <= '0;
      nout_q     <= '0;
      wbase_q    <= '0;
      ibase_q    <= '0;
      obase_q    <= '0;
      mxen_q     <= 1'b0;
      mxpl_q     <= 1'b0;
      o_q        <= '0;
      b_q        <= '0;
      t_q        <= '0;
      dcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mul_mode_q <= '0;
      acc_clr_q  <= 1'b0;
      acc_sh_q   <= 1'b0;
      max_en_q   <= 1'b0;
      max_clr_q  <= 1'b0;
      max_pool_q <= 1'b0;
      rdw_addr_q <= '0;
      rdd_en_q   <= 1'b0;
      rdd_addr_q <= '0;
      wrd_en_q   <= 1'b0;
      wrd_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      iprec_q    <= iprec_d;
      len_q      <= len_d;
      nout_q     <= nout_d;
      wbase_q    <= wbase_d;
      ibase_q    <= ibase_d;
      obase_q    <= obase_d;
      mxen_q     <= mxen_d;
      mxpl_q     <= mxpl_d;
      o_q        <= o_d;
      b_q        <= b_d;
      t_q        <= t_d;
      dcnt_q     <= dcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mul_mode_q <= mul_mode_d;
      acc_clr_q  <= acc_clr_d;
      acc_sh_q   <= acc_sh_d;
      max_en_q   <= max_en_d;
      max_clr_q  <= max_clr_d;
      max_pool_q <= max_pool_d;
      rdw_addr_q <= rdw_addr_d;
      rdd_en_q   <= rdd_en_d;
      rdd_addr_q <= rdd_addr_d;
      wrd_en_q   <= wrd_en_d;
      wrd_addr_q <= wrd_addr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mul_mode = mul_mode_q;
  assign acc_clr  = acc_clr_q;
  assign acc_sh   = acc_sh_q;
  assign max_en   = max_en_q;
  assign max_clr  = max_clr_q;
  assign max_pool = max_pool_q;
  assign rdw_addr = rdw_addr_q;
  assign rdd_en   = rdd_en_q;
  assign rdd_addr = rdd_addr_q;
  assign wrd_en   = wrd_en_q;
  assign wrd_addr = wrd_addr_q;

endmodule
`default_nettype wire
